layer2_argmax: RTL and testbench

//  Output stage of the binary MLP; sits directly downstream of layer 1. Streams layer-1 results from SDRAM
//  (200 one-bit hidden nodes per sample, 13 x 16-bit words) and computes 10 output nodes (int8 bias + int8 weights).

---
 rtl/layer2_argmax_pkg.sv | 41 ++++
 rtl/layer2_argmax_tracker.sv | 29 ++
 rtl/layer2_argmax.sv | 196 +++++++++++++++++++
 tb/tb_layer2_argmax.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/layer2_argmax_pkg.sv
// Shared constants, state codes and helpers for the layer-2 argmax output stage.
package layer2_argmax_pkg;

  localparam int NUM_NODES       = 10;
  localparam int IN_BITS         = 200;
  localparam int IN_WORDS        = 13;
  localparam int NODE_STRIDE     = 202;
  localparam int KERNEL_WORDS    = NUM_NODES * NODE_STRIDE / 2;
  localparam int DEF_NUM_SAMPLES = 100;

  localparam logic [31:0] WEIGHT_ADDR = 32'h0001_0000;
  localparam logic [31:0] INPUT_ADDR  = 32'h0000_E000;
  localparam logic [31:0] RESULT_ADDR = 32'h0001_2000;

  localparam logic [10:0] KERNEL_WORDS_W = 11'(KERNEL_WORDS);
  localparam logic [10:0] IN_WORDS_W     = 11'(IN_WORDS);
  localparam logic [10:0] LAST_IN_WORD   = 11'(IN_WORDS - 1);
  localparam logic [31:0] IN_STEP        = 32'(IN_WORDS);
  localparam logic [11:0] STRIDE_W       = 12'(NODE_STRIDE);
  localparam logic [3:0]  LAST_NODE      = 4'(NUM_NODES - 1);
  localparam logic [6:0]  CALC_LAST      = 7'd100;
  localparam logic [15:0] MAX_INIT       = 16'h8000;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LDW   = 4'd1,
    ST_INIT  = 4'd2,
    ST_LDIN  = 4'd3,
    ST_BIAS  = 4'd4,
    ST_CALC  = 4'd5,
    ST_CMP   = 4'd6,
    ST_WRITE = 4'd7,
    ST_SDONE = 4'd8,
    ST_DONE  = 4'd9
  } l2_state_t;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/layer2_argmax_tracker.sv
// Running maximum of the per-node sums; a strict signed compare keeps the
// lowest node index on ties.
module layer2_argmax_tracker
  import layer2_argmax_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        update,
  input  logic [15:0] value,
  input  logic [3:0]  index,
  output logic [15:0] max_val,
  output logic [3:0]  max_idx
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (clear) begin
      max_val <= MAX_INIT;
      max_idx <= '0;
    end else if (update && ($signed(value) > $signed(max_val))) begin
      max_val <= value;
      max_idx <= index;
    end
  end

endmodule

// File: rtl/layer2_argmax.sv
// Layer-2 output stage: loads the kernel into an external byte BRAM, streams
// each 200-bit hidden vector from SDRAM and writes back the argmax class.
module layer2_argmax
  import layer2_argmax_pkg::*;
#(
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        done,
  output logic [3:0]  state,
  output logic [3:0]  class_out,
  output logic        read_n,
  output logic        write_n,
  output logic        chipselect,
  output logic [1:0]  byteenable,
  output logic [31:0] address,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        readdatavalid,
  input  logic        waitrequest,
  output logic [11:0] s1_adr,
  output logic [11:0] s2_adr,
  output logic [7:0]  s1_d,
  output logic [7:0]  s2_d,
  input  logic [7:0]  s1_q,
  input  logic [7:0]  s2_q,
  output logic        s1_w,
  output logic        s2_w
);

  localparam logic [6:0] LAST_SAMPLE = 7'(NUM_SAMPLES - 1);

  l2_state_t cur;
  l2_state_t nxt;

  logic [10:0]        sent;
  logic [10:0]        received;
  logic [10:0]        count_target;
  logic               loading;
  logic               rd_req;
  logic               rd_accept;
  logic               rd_valid;
  logic [IN_BITS-1:0] vec;
  logic [15:0]        acc;
  logic [3:0]         node;
  logic [11:0]        node_base;
  logic [6:0]         calc_cnt;
  logic [6:0]         sample;
  logic [31:0]        in_base;
  logic [15:0]        max_val;
  logic [3:0]         max_idx;

  assign loading      = (cur == ST_LDW) || (cur == ST_LDIN);
  assign count_target = (cur == ST_LDW) ? KERNEL_WORDS_W : IN_WORDS_W;
  assign rd_req       = loading && (sent < count_target);
  assign rd_accept    = rd_req && !waitrequest;
  // Responses are only counted while a load is expecting them; strays are dropped.
  assign rd_valid     = loading && readdatavalid && (received < count_target);

  assign state      = cur;
  assign done       = (cur == ST_DONE);
  assign read_n     = !rd_req;
  assign write_n    = (cur != ST_WRITE);
  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign writedata  = {12'b0, max_idx};

  assign s1_d = readdata[7:0];
  assign s2_d = readdata[15:8];
  assign s1_w = (cur == ST_LDW) && rd_valid;
  assign s2_w = (cur == ST_LDW) && rd_valid;

  always_comb begin
    case (cur)
      ST_LDW:   address = WEIGHT_ADDR + {21'b0, sent};
      ST_LDIN:  address = in_base + {21'b0, sent};
      ST_WRITE: address = RESULT_ADDR + {25'b0, sample};
      default:  address = '0;
    endcase
  end

  // BRAM ports: kernel fill in LDW, bias fetch in BIAS, weight pairs in CALC.
  always_comb begin
    s1_adr = '0;
    s2_adr = '0;
    case (cur)
      ST_LDW: begin
        s1_adr = {received, 1'b0};
        s2_adr = {received, 1'b1};
      end
      ST_BIAS: s1_adr = node_base;
      ST_CALC: begin
        s1_adr = node_base + {4'b0, calc_cnt, 1'b0} + 12'd1;
        s2_adr = node_base + {4'b0, calc_cnt, 1'b0} + 12'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= ST_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      ST_IDLE:  if (ready) nxt = ST_LDW;
      ST_LDW:   if (received == KERNEL_WORDS_W) nxt = ST_INIT;
      ST_INIT:  nxt = ST_LDIN;
      ST_LDIN:  if (received == IN_WORDS_W) nxt = ST_BIAS;
      ST_BIAS:  nxt = ST_CALC;
      ST_CALC:  if (calc_cnt == CALC_LAST) nxt = ST_CMP;
      ST_CMP:   nxt = (node == LAST_NODE) ? ST_WRITE : ST_BIAS;
      ST_WRITE: if (!waitrequest) nxt = ST_SDONE;
      ST_SDONE: nxt = (sample == LAST_SAMPLE) ? ST_DONE : ST_INIT;
      ST_DONE:  if (!ready) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // The hidden vector is rotated two bits per accumulate cycle, so after the
  // 100 pairs of one node it is back in place for the next node.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent      <= '0;
      received  <= '0;
      vec       <= '0;
      acc       <= '0;
      node      <= '0;
      node_base <= '0;
      calc_cnt  <= '0;
      sample    <= '0;
      in_base   <= '0;
      class_out <= '0;
    end else begin
      if (rd_accept) sent <= sent + 11'd1;
      if (rd_valid)  received <= received + 11'd1;
      case (cur)
        ST_IDLE: begin
          sent     <= '0;
          received <= '0;
          sample   <= '0;
          in_base  <= INPUT_ADDR;
        end
        ST_INIT: begin
          sent      <= '0;
          received  <= '0;
          vec       <= '0;
          node      <= '0;
          node_base <= '0;
        end
        ST_LDIN: begin
          if (rd_valid) begin
            if (received == LAST_IN_WORD) vec <= {readdata[15:8], vec[IN_BITS-1:8]};
            else                          vec <= {readdata, vec[IN_BITS-1:16]};
          end
        end
        ST_BIAS: calc_cnt <= '0;
        ST_CALC: begin
          calc_cnt <= calc_cnt + 7'd1;
          if (calc_cnt == 7'd0) begin
            acc <= sext8(s1_q);
          end else begin
            acc <= acc + (vec[0] ? sext8(s1_q) : 16'd0) + (vec[1] ? sext8(s2_q) : 16'd0);
            vec <= {vec[1:0], vec[IN_BITS-1:2]};
          end
        end
        ST_CMP: begin
          node      <= node + 4'd1;
          node_base <= node_base + STRIDE_W;
        end
        ST_WRITE: if (!waitrequest) class_out <= max_idx;
        ST_SDONE: begin
          sample  <= sample + 7'd1;
          in_base <= in_base + IN_STEP;
        end
        default: ;
      endcase
    end
  end

  layer2_argmax_tracker u_tracker (
    .clk     (clk),
    .reset   (reset),
    .clear   (cur == ST_INIT),
    .update  (cur == ST_CMP),
    .value   (acc),
    .index   (node),
    .max_val (max_val),
    .max_idx (max_idx)
  );

endmodule

// File: tb/tb_layer2_argmax.sv
// Bench for layer2_argmax: Avalon slave with random stalls/latency, byte BRAM,
// and a direct arithmetic argmax reference per sample.
module tb_layer2_argmax;
  import layer2_argmax_pkg::*;

  localparam int NS         = 3;
  localparam int RUN_BUDGET = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic        done;
  logic [3:0]  state;
  logic [3:0]  class_out;
  logic        read_n;
  logic        write_n;
  logic        chipselect;
  logic [1:0]  byteenable;
  logic [31:0] address;
  logic [15:0] writedata;
  logic [15:0] readdata = '0;
  logic        readdatavalid = 1'b0;
  logic        waitrequest = 1'b0;
  logic [11:0] s1_adr;
  logic [11:0] s2_adr;
  logic [7:0]  s1_d;
  logic [7:0]  s2_d;
  logic [7:0]  s1_q = '0;
  logic [7:0]  s2_q = '0;
  logic        s1_w;
  logic        s2_w;

  int checks = 0;
  int errors = 0;

  logic [7:0]  kern [0:4095];
  logic [15:0] inw  [0:NS*IN_WORDS-1];
  logic [7:0]  bram [0:4095];
  int          res     [0:NS-1];
  int          res_run [0:NS-1];
  int          run_id = 0;
  int          wait_pct = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          writes_seen = 0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } rd_t;
  rd_t rq[$];

  always #5 clk = ~clk;

  layer2_argmax #(.NUM_SAMPLES(NS)) dut (
    .clk(clk), .reset(reset), .ready(ready), .done(done), .state(state),
    .class_out(class_out), .read_n(read_n), .write_n(write_n),
    .chipselect(chipselect), .byteenable(byteenable), .address(address),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .s1_adr(s1_adr), .s2_adr(s2_adr),
    .s1_d(s1_d), .s2_d(s2_d), .s1_q(s1_q), .s2_q(s2_q), .s1_w(s1_w), .s2_w(s2_w)
  );

  always @(posedge clk) begin
    if (s1_w) bram[s1_adr] <= s1_d;
    if (s2_w) bram[s2_adr] <= s2_d;
    s1_q <= bram[s1_adr];
    s2_q <= bram[s2_adr];
  end

  function automatic logic [15:0] sdram_rd(input logic [31:0] a);
    int k;
    if (a >= WEIGHT_ADDR && a < WEIGHT_ADDR + 32'(KERNEL_WORDS)) begin
      k = int'(a - WEIGHT_ADDR);
      return {kern[2*k+1], kern[2*k]};
    end
    if (a >= INPUT_ADDR && a < INPUT_ADDR + 32'(NS*IN_WORDS))
      return inw[int'(a - INPUT_ADDR)];
    return 16'hDEAD;
  endfunction

  // Avalon slave: responses in order, each 1..8 cycles after acceptance.
  always @(negedge clk) begin
    int d;
    int idx;
    if (reset) begin
      rq.delete();
      readdatavalid = 1'b0;
      waitrequest   = 1'b0;
      last_due      = 0;
    end else begin
      cyc++;
      readdatavalid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        readdata      = sdram_rd(rq[0].a);
        readdatavalid = 1'b1;
        void'(rq.pop_front());
      end
      waitrequest = (int'($urandom_range(99)) < wait_pct);
      if (!read_n && !waitrequest) begin
        d = cyc + int'($urandom_range(8, 1));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        rq.push_back('{address, d});
      end
      if (!write_n && !waitrequest) begin
        writes_seen++;
        idx = int'(address - RESULT_ADDR);
        if (idx >= 0 && idx < NS) begin
          res[idx]     = int'(writedata);
          res_run[idx] = run_id;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int hidden_bit(input int s, input int i);
    logic [15:0] w;
    int pos;
    w   = inw[s*IN_WORDS + i/16];
    pos = (i >= 192) ? (i - 192 + 8) : (i % 16);
    return int'(w[pos]);
  endfunction

  function automatic int ref_class(input int s);
    int best;
    int best_sum;
    int sum;
    best     = 0;
    best_sum = -1000000;
    for (int n = 0; n < NUM_NODES; n++) begin
      sum = int'($signed(kern[n*NODE_STRIDE]));
      for (int i = 0; i < IN_BITS; i++)
        if (hidden_bit(s, i) == 1) sum += int'($signed(kern[n*NODE_STRIDE + 1 + i]));
      if (sum > best_sum) begin
        best_sum = sum;
        best     = n;
      end
    end
    return best;
  endfunction

  task automatic applyStimulus(input int mode);
    for (int b = 0; b < 4096; b++) kern[b] = 8'h00;
    for (int n = 0; n < NUM_NODES; n++) begin
      for (int i = 0; i <= IN_BITS; i++) begin
        case (mode)
          0: kern[n*NODE_STRIDE + i] = (i == 0) ? ((n == 3) ? 8'd5 : 8'hFF) : 8'h00;
          1: kern[n*NODE_STRIDE + i] = (i != 0 && n == 7) ? 8'd1 : 8'h00;
          2: kern[n*NODE_STRIDE + i] = (n == 2 || n == 5) ? ((i == 0) ? 8'd0 : 8'd3)
                                                          : ((i == 0) ? 8'hFF : 8'h00);
          3: kern[n*NODE_STRIDE + i] = 8'h80;
          default: kern[n*NODE_STRIDE + i] = 8'($urandom());
        endcase
      end
    end
    for (int w = 0; w < NS*IN_WORDS; w++)
      inw[w] = (mode == 1 || mode == 3) ? 16'hFFFF : 16'($urandom());
    wait_pct = (mode >= 4) ? 30 : 10;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_state"}, int'(state), 0);
    checkOutput({tag, "_read_n"}, int'(read_n), 1);
    checkOutput({tag, "_write_n"}, int'(write_n), 1);
    checkOutput({tag, "_address"}, int'(address), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_class"}, int'(class_out), 0);
    checkOutput({tag, "_s_w"}, int'(s1_w) + int'(s2_w), 0);
  endtask

  task automatic runPass(input string tag, input int directed);
    int exp_cls [NS];
    int n;
    int got;
    run_id++;
    for (int s = 0; s < NS; s++) exp_cls[s] = ref_class(s);
    ready = 1'b1;
    n = 0;
    while (!done && n < RUN_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, int'(done), 1);
    for (int s = 0; s < NS; s++) begin
      got = (res_run[s] == run_id) ? res[s] : -1;
      checkOutput($sformatf("%s_s%0d", tag, s), got, exp_cls[s]);
      if (directed >= 0) checkOutput($sformatf("%s_dir%0d", tag, s), got, directed);
    end
    checkOutput({tag, "_class_out"}, int'(class_out), exp_cls[NS-1]);
    ready = 1'b0;
    n = 0;
    while (state != 4'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, int'(state), 0);
  endtask

  initial begin
    int n;
    int w0;
    for (int s = 0; s < NS; s++) res_run[s] = 0;
    repeat (3) @(negedge clk);
    checkResetState("por");
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(0); runPass("zero_w", 3);
    applyStimulus(1); runPass("node7", 7);
    applyStimulus(2); runPass("tie", 2);
    applyStimulus(3); runPass("neg_max", 0);
    applyStimulus(4); runPass("random", -1);

    // Abort in the middle of the second sample's accumulation.
    applyStimulus(5);
    w0    = writes_seen;
    ready = 1'b1;
    n     = 0;
    while (!(writes_seen > w0 && state == 4'd5) && n < RUN_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_calc", int'(state), 5);
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkResetState("midrun");
    @(negedge clk);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    runPass("rerun", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
